// File: rtl/romulus_tbc_sequencer_if.sv
// Control bundle between the mode FSM (master), the TBC sequencer (slave)
// and the strobe inputs of romulus_datapath.
interface romulus_tbc_sequencer_if #(
    parameter int CONSTW = 6
);
    logic              start;
    logic              key_update;
    logic              cnt_init;
    logic              key_valid;
    logic              key_ready;
    logic              busy;
    logic              done;
    logic              srst;
    logic              sen;
    logic              senc;
    logic              xrst;
    logic              xen;
    logic              xenc;
    logic              yen;
    logic              yenc;
    logic              zrst;
    logic              zen;
    logic              zenc;
    logic              correct_cnt;
    logic [CONSTW-1:0] constant;

    modport master (
        output start, key_update, cnt_init, key_valid,
        input  key_ready, busy, done,
        input  srst, sen, senc, xrst, xen, xenc, yen, yenc,
        input  zrst, zen, zenc, correct_cnt, constant
    );

    modport slave (
        input  start, key_update, cnt_init, key_valid,
        output key_ready, busy, done,
        output srst, sen, senc, xrst, xen, xenc, yen, yenc,
        output zrst, zen, zenc, correct_cnt, constant
    );
endinterface

// File: rtl/romulus_tbc_sequencer.sv
// Sequencer for one Romulus TBC call: optional counter init and key reload,
// ROUNDS SKINNY rounds, one counter-correction cycle, then a done pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; latches key_update
// CINIT   | one cycle, counter register loaded with domain (zrst)
// LOADKEY | key shifted in from sdi, one word per key_valid beat
// ROUND   | one SKINNY round per cycle, rc LFSR stepping
// CORRECT | one cycle, key/tweak rewind, counter takes pre-permutation value
// DONE    | one-cycle done pulse, round state cleared
module romulus_tbc_sequencer #(
    parameter int BUSW   = 32,
    parameter int ROUNDS = 40,
    parameter int CONSTW = 6
) (
    input logic                   clk,
    input logic                   rst,
    romulus_tbc_sequencer_if.slave bus
);
    localparam int KEYBEATS = 128 / BUSW;
    localparam int BW       = (KEYBEATS > 1) ? $clog2(KEYBEATS) : 1;
    localparam int RW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [BW-1:0] BEAT_LAST  = BW'(KEYBEATS - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CINIT,
        S_LOADKEY,
        S_ROUND,
        S_CORRECT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     round_q, round_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [CONSTW-1:0] rc_q, rc_d;
    logic              kupd_q, kupd_d;

    function automatic logic [CONSTW-1:0] rc_step(input logic [CONSTW-1:0] r);
        return {r[CONSTW-2:0], r[CONSTW-1] ^ r[CONSTW-2] ^ 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            beat_q  <= '0;
            rc_q    <= '0;
            kupd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            beat_q  <= beat_d;
            rc_q    <= rc_d;
            kupd_q  <= kupd_d;
        end
    end

    // The rc LFSR steps on every transition into ROUND so that the first
    // round already sees constant 0x01.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        beat_d  = beat_q;
        rc_d    = rc_q;
        kupd_d  = kupd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    kupd_d = bus.key_update;
                    if (bus.cnt_init) begin
                        state_d = S_CINIT;
                    end else if (bus.key_update) begin
                        state_d = S_LOADKEY;
                    end else begin
                        state_d = S_ROUND;
                        rc_d    = rc_step(rc_q);
                    end
                end
            end
            S_CINIT: begin
                if (kupd_q) begin
                    state_d = S_LOADKEY;
                end else begin
                    state_d = S_ROUND;
                    rc_d    = rc_step(rc_q);
                end
            end
            S_LOADKEY: begin
                if (bus.key_valid) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = S_ROUND;
                        rc_d    = rc_step(rc_q);
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_ROUND: begin
                rc_d = rc_step(rc_q);
                if (round_q == ROUND_LAST) begin
                    state_d = S_CORRECT;
                end else begin
                    round_d = round_q + RW'(1);
                end
            end
            S_CORRECT: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                rc_d    = '0;
                round_d = '0;
                kupd_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.key_ready   = 1'b0;
        bus.busy        = (state_q != S_IDLE);
        bus.done        = 1'b0;
        bus.srst        = 1'b0;
        bus.sen         = 1'b0;
        bus.senc        = 1'b0;
        bus.xrst        = 1'b0;
        bus.xen         = 1'b0;
        bus.xenc        = 1'b0;
        bus.yen         = 1'b0;
        bus.yenc        = 1'b0;
        bus.zrst        = 1'b0;
        bus.zen         = 1'b0;
        bus.zenc        = 1'b0;
        bus.correct_cnt = 1'b0;
        bus.constant    = '0;
        case (state_q)
            S_CINIT: begin
                bus.zrst = 1'b1;
            end
            S_LOADKEY: begin
                bus.key_ready = 1'b1;
                bus.xrst      = bus.key_valid;
            end
            S_ROUND: begin
                bus.sen      = 1'b1;
                bus.senc     = 1'b1;
                bus.xen      = 1'b1;
                bus.xenc     = 1'b1;
                bus.yen      = 1'b1;
                bus.yenc     = 1'b1;
                bus.zen      = 1'b1;
                bus.zenc     = 1'b1;
                bus.constant = rc_q;
            end
            S_CORRECT: begin
                bus.xen         = 1'b1;
                bus.yen         = 1'b1;
                bus.zen         = 1'b1;
                bus.correct_cnt = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Randomized bench: each TBC call is expanded into its expected per-cycle
// strobe schedule and compared cycle by cycle against the sequencer.
module tb_romulus_tbc_sequencer;
    localparam int BUSW     = 32;
    localparam int ROUNDS   = 40;
    localparam int CONSTW   = 6;
    localparam int KEYBEATS = 128 / BUSW;

    // flag bits: busy done kr xrst srst sen senc xen xenc yen yenc zrst zen zenc cc
    localparam logic [14:0] F_CINIT = 15'((1 << 14) | (1 << 3));
    localparam logic [14:0] F_LOAD  = 15'((1 << 14) | (1 << 12));
    localparam logic [14:0] F_XRST  = 15'(1 << 11);
    localparam logic [14:0] F_ROUND = 15'((1 << 14) | (1 << 9) | (1 << 8) | (1 << 7) |
                                          (1 << 6) | (1 << 5) | (1 << 4) | (1 << 2) | (1 << 1));
    localparam logic [14:0] F_CORR  = 15'((1 << 14) | (1 << 7) | (1 << 5) | (1 << 2) | (1 << 0));
    localparam logic [14:0] F_DONE  = 15'((1 << 14) | (1 << 13));

    logic clk = 1'b0;
    logic rst;
    logic [BUSW-1:0] sdi;
    logic [127:0]    key_obs;
    logic [127:0]    key_exp;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_exp = 0;
    int stalls [KEYBEATS];
    logic [5:0] rc_ref [7];

    romulus_tbc_sequencer_if #(.CONSTW(CONSTW)) bus ();

    romulus_tbc_sequencer #(
        .BUSW  (BUSW),
        .ROUNDS(ROUNDS),
        .CONSTW(CONSTW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // datapath-side key register, shifted only by the DUT's xrst strobe
    always @(posedge clk) begin
        if (bus.xrst) key_obs <= {key_obs[127-BUSW:0], sdi};
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [20:0] obs();
        return {bus.busy, bus.done, bus.key_ready, bus.xrst, bus.srst, bus.sen, bus.senc,
                bus.xen, bus.xenc, bus.yen, bus.yenc, bus.zrst, bus.zen, bus.zenc,
                bus.correct_cnt, bus.constant};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One call: start in the IDLE cycle, then the expected schedule.
    // abort_at >= 0 asserts rst in that schedule cycle instead of finishing.
    task automatic run_call(input bit kupd, input bit cini, input bit mid_start,
                            input bit hold, input int abort_at);
        logic [20:0] exp_q [$];
        bit          kv_q  [$];
        bit          acc_q [$];
        logic [5:0]  rc;
        int          base;
        int          lat_exp;
        int          lat_got;
        exp_q.delete(); kv_q.delete(); acc_q.delete();
        lat_exp = ROUNDS + 2;
        if (cini) begin
            exp_q.push_back({F_CINIT, 6'h00}); kv_q.push_back(1'($urandom)); acc_q.push_back(0);
            lat_exp += 1;
        end
        if (kupd) begin
            for (int b = 0; b < KEYBEATS; b++) begin
                for (int s = 0; s < stalls[b]; s++) begin
                    exp_q.push_back({F_LOAD, 6'h00}); kv_q.push_back(0); acc_q.push_back(0);
                end
                exp_q.push_back({F_LOAD | F_XRST, 6'h00}); kv_q.push_back(1); acc_q.push_back(1);
                lat_exp += 1 + stalls[b];
            end
        end
        base = exp_q.size();
        rc = 6'h00;
        for (int r = 0; r < ROUNDS; r++) begin
            if (r < 7) rc = rc_ref[r];
            else       rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
            exp_q.push_back({F_ROUND, rc}); kv_q.push_back(1'($urandom)); acc_q.push_back(0);
        end
        exp_q.push_back({F_CORR, 6'h00}); kv_q.push_back(1'($urandom)); acc_q.push_back(0);
        exp_q.push_back({F_DONE, 6'h00}); kv_q.push_back(1'($urandom)); acc_q.push_back(0);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.key_update = kupd; bus.cnt_init = cini;
        bus.key_valid = 1'($urandom); sdi = $urandom;
        @(negedge clk);
        check_eq("idle_at_start", 128'(obs()), 128'(0));

        lat_got = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            bus.start      = hold || (mid_start && i == base + 10);
            bus.key_update = 1'($urandom);
            bus.cnt_init   = 1'($urandom);
            bus.key_valid  = kv_q[i];
            sdi            = $urandom;
            if (acc_q[i]) key_exp = {key_exp[127-BUSW:0], sdi};
            if (i == abort_at) rst = 1'b1;
            @(negedge clk);
            check_eq($sformatf("cyc%0d", i), 128'(obs()), 128'(exp_q[i]));
            if (bus.done && lat_got < 0) lat_got = i + 1;
            if (i == abort_at) begin
                @(posedge clk); #1;
                rst = 1'b0; bus.start = 1'b0; bus.key_valid = 1'($urandom);
                @(negedge clk);
                check_eq("after_abort", 128'(obs()), 128'(0));
                return;
            end
        end
        done_exp++;
        check_eq("latency", 128'(lat_got), 128'(lat_exp));
    endtask

    initial begin
        rc_ref[0] = 6'h01; rc_ref[1] = 6'h03; rc_ref[2] = 6'h07; rc_ref[3] = 6'h0F;
        rc_ref[4] = 6'h1F; rc_ref[5] = 6'h3E; rc_ref[6] = 6'h3D;
        key_obs = '0; key_exp = '0; sdi = '0;
        bus.start = 1'b0; bus.key_update = 1'b0; bus.cnt_init = 1'b0; bus.key_valid = 1'b0;
        for (int b = 0; b < KEYBEATS; b++) stalls[b] = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.key_valid = 1'b1;
        @(negedge clk);
        check_eq("reset", 128'(obs()), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check_eq("reset_release", 128'(obs()), 128'(0));

        run_call(0, 0, 0, 0, -1);
        run_call(1, 0, 0, 0, -1);
        check_eq("key_load", key_obs, key_exp);
        stalls[2] = 3;
        run_call(1, 0, 0, 0, -1);
        stalls[2] = 0;
        check_eq("key_stall", key_obs, key_exp);
        run_call(0, 1, 0, 0, -1);
        run_call(1, 1, 0, 0, -1);
        run_call(0, 0, 1, 1, -1);
        run_call(0, 0, 0, 0, -1);
        run_call(0, 0, 0, 0, 20);
        run_call(1, 0, 0, 0, 2);
        run_call(1, 0, 0, 0, -1);
        check_eq("key_after_abort", key_obs, key_exp);

        for (int n = 0; n < 12; n++) begin
            for (int b = 0; b < KEYBEATS; b++) stalls[b] = $urandom_range(0, 2);
            run_call(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : -1);
        end

        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            bus.key_valid = 1'($urandom);
            @(negedge clk);
            check_eq("final_idle", 128'(obs()), 128'(0));
        end
        check_eq("done_count", 128'(done_cnt), 128'(done_exp));
        check_eq("key_final", key_obs, key_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/romulus_tbc_sequencer.md
Name: romulus_tbc_sequencer

Overview:
Sequencer for the Romulus TBC datapath. It drives the per-register enable, select and reset strobes (s*/x*/y*/z*), the SKINNY round constant and the counter-correction select for one tweakable block-cipher call. On `start` it can optionally re-initialise the block counter and reload the key from `sdi`. It then runs ROUNDS encryption rounds and one correction cycle, and finally pulses `done`. It sits between the mode-level FSM (the requester) and `romulus_datapath`.

Parameters:
BUSW, 32, width of `sdi`; 128 must be a multiple of BUSW; KEYBEATS = 128/BUSW.
ROUNDS, 40, SKINNY-128-384+ rounds per TBC call.
CONSTW, 6, round-constant width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request one TBC call; accepted only in IDLE
key_update  in  1  sampled with start: reload key before rounds
cnt_init  in  1  sampled with start: reset domain/counter register before rounds
key_valid  in  1  key word on sdi valid
key_ready  out  1  sequencer accepts key word (LOADKEY only)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, TBC call complete
srst  out  1  state register clear; tied 0 (mode FSM owns it)
sen  out  1  state register enable
senc  out  1  state register takes TBC output
xrst  out  1  key register shift-load strobe
xen  out  1  key register enable
xenc  out  1  key register takes TBC output
yen  out  1  tweak register enable
yenc  out  1  tweak register takes TBC output
zrst  out  1  counter register init to domain
zen  out  1  counter register enable
zenc  out  1  counter register takes TBC output
correct_cnt  out  1  counter correction uses the pre-permutation value
constant  out  CONSTW  current round constant

Behaviour:
- States: IDLE, CINIT, LOADKEY, ROUND, CORRECT, DONE. All outputs are Moore-decoded from registered state and counters.
- Reset: state = IDLE, round counter = 0, beat counter = 0, rc LFSR = 0, latched flags = 0. Every output is 0, including `constant` = 0.
- IDLE: when start = 1, latch key_update and cnt_init. Next state:
  - CINIT if cnt_init;
  - else LOADKEY if key_update;
  - else ROUND.
- start while busy = 1 is ignored. It is neither queued nor counted.
- CINIT, one cycle: zrst = 1, all enables 0. Next state is LOADKEY if the latched key_update = 1, else ROUND.
- LOADKEY:
  - key_ready = 1. xrst = key_valid (the register shifts in one word per accepted beat).
  - The beat counter increments on key_valid & key_ready. When key_valid = 0 the state holds with no beat.
  - After beat KEYBEATS-1 is accepted, next state is ROUND.
- ROUND:
  - sen = senc = xen = xenc = yen = yenc = zen = zenc = 1.
  - rc LFSR: rc' = {rc[4:0], rc[5]^rc[4]^1}. It updates on entry to and on each cycle of ROUND, so constant = 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3E, 0x3D, ... in rounds 1, 2, 3, ...
  - The round counter runs 0..ROUNDS-1. After the cycle with count ROUNDS-1, next state is CORRECT.
- CORRECT, one cycle:
  - xen = yen = zen = 1, xenc = yenc = zenc = 0, correct_cnt = 1, sen = 0, constant = 0.
  - The key and tweak return to their initial schedules and the counter advances by one LFSR step.
- DONE, one cycle: done = 1, busy = 1. The rc LFSR and round counter clear. Next state is IDLE.
- Latency: with start sampled at edge t and no flags, ROUND occupies cycles t+1 .. t+ROUNDS, CORRECT is t+ROUNDS+1, done is t+ROUNDS+2.
  - cnt_init adds 1 cycle.
  - key_update adds KEYBEATS cycles plus any key_valid stall cycles.
- A fresh start is accepted at the earliest in the cycle after done.
- rst asserted in any state (including mid-LOADKEY or mid-ROUND) aborts the call: IDLE next cycle, all strobes 0, no done pulse.
- Partial key beats are discarded. The datapath contents become undefined and the next call must set key_update.
- Exactly one of {senc-path, correct} is active per cycle. xrst and xen are never both 1. zrst and zen are never both 1.

Test Plan:
- Reset, then start = 1, flags = 0 (ROUNDS = 40) -> busy rises the next cycle; 40 cycles with all enc strobes = 1; constant sequence starts 01, 03, 07, 0F, 1F, 3E, 3D; one CORRECT cycle with correct_cnt = 1; done = 1 exactly 42 cycles after start.
- start with key_update = 1, BUSW = 32, key_valid high throughout -> 4 cycles of key_ready = xrst = 1 carrying sdi words A, B, C, D; key register = {A, B, C, D}; done 46 cycles after start.
- key_update = 1 with key_valid deasserted for 3 cycles after beat 2 -> beat counter holds, xrst = 0 during the stall, done 49 cycles after start, key still {A, B, C, D}.
- cnt_init = 1 with domain = 0x48 -> single zrst pulse in the cycle after start; counter register = {01000000000000, 48, 0}; first ROUND one cycle later.
- start pulsed again at round 10, and start held high through DONE -> mid-call start ignored; a second call begins only after done; exactly two done pulses across 90 cycles.
- rst asserted at round 20, then start -> no done for the aborted call; after rst all outputs are 0; constant restarts at 01 in the new call.
